// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - command encodings and output-register states for spi_ram_burst
package spi_ram_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/spi_ram_burst_if.sv
// rtl/spi_ram_burst_if.sv - command input, read-data output and status flags of spi_ram_burst
interface spi_ram_burst_if
    import spi_ram_pkg::*;
#(
    parameter int DATA_W = 8
);
    logic [DATA_W+CMD_W-1:0] din;
    logic                    rx_valid;
    logic                    tx_ready;
    logic [DATA_W-1:0]       dout;
    logic                    tx_valid;
    logic                    addr_err;
    logic                    ovf;

    modport slave (
        input  din, rx_valid, tx_ready,
        output dout, tx_valid, addr_err, ovf
    );

    modport master (
        output din, rx_valid, tx_ready,
        input  dout, tx_valid, addr_err, ovf
    );
endinterface

// File: rtl/sp_ram_core.sv
// rtl/sp_ram_core.sv - word memory with synchronous write and registered read port
module sp_ram_core #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Callers only assert we_i/re_i for in-range addresses, so the low bits suffice.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i[IDX_W-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i[IDX_W-1:0]];
        end else if (clr_i) begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/spi_ram_burst.sv
// rtl/spi_ram_burst.sv - command decoder, auto-increment address counters, output handshake and flags
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input logic             clk,
    input logic             rst,
    spi_ram_burst_if.slave  bus
);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    out_state_e        state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              addr_err_q, addr_err_d;
    logic              ovf_q, ovf_d;
    logic              mem_we, mem_re, mem_clr;
    logic              out_free;
    cmd_e              cmd;
    logic [ADDR_W-1:0] addr_pl;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_EXT;
    endfunction

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    assign cmd      = cmd_e'(bus.din[DATA_W+CMD_W-1:DATA_W]);
    assign addr_pl  = bus.din[ADDR_W-1:0];
    assign out_free = (state_q == ST_EMPTY) || bus.tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            waddr_q    <= '0;
            raddr_q    <= '0;
            addr_err_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            addr_err_q <= addr_err_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        addr_err_d = addr_err_q;
        ovf_d      = ovf_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_clr    = 1'b0;

        if (state_q == ST_FULL && bus.tx_ready) begin
            state_d = ST_EMPTY;
        end

        if (bus.rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: begin
                    waddr_d = addr_pl;
                    if (!in_range(addr_pl)) addr_err_d = 1'b1;
                end
                CMD_WR_DATA: begin
                    if (in_range(waddr_q)) begin
                        mem_we = 1'b1;
                        if (AUTO_INC != 0) waddr_d = wrap_inc(waddr_q);
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    raddr_d = addr_pl;
                    if (!in_range(addr_pl)) addr_err_d = 1'b1;
                end
                default: begin
                    // A read that finds the output register occupied is dropped, not queued.
                    if (out_free) begin
                        state_d = ST_FULL;
                        if (in_range(raddr_q)) begin
                            mem_re = 1'b1;
                            if (AUTO_INC != 0) raddr_d = wrap_inc(raddr_q);
                        end else begin
                            mem_clr    = 1'b1;
                            addr_err_d = 1'b1;
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            endcase
        end
    end

    sp_ram_core #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .waddr_i (waddr_q),
        .wdata_i (bus.din[DATA_W-1:0]),
        .re_i    (mem_re),
        .clr_i   (mem_clr),
        .raddr_i (raddr_q),
        .rdata_o (bus.dout)
    );

    assign bus.tx_valid = (state_q == ST_FULL);
    assign bus.addr_err = addr_err_q;
    assign bus.ovf      = ovf_q;
endmodule
